hazard_unit: RTL
================

# hazard_unit

Pipeline hazard controller for the 5-stage MIPS core. It drives the stall inputs of the F and D pipeline registers and the flush of the D/E register. It also generates the E-stage and D-stage forwarding selects. It sequences the multi-cycle multiply/divide unit with a busy counter, so HI/LO consumers interlock until the result is written. It sits beside the datapath and observes register specifiers and control bits from the D, E, M and W stages.

## Interface
Parameters:
- MULT_CYCLES, 4, cycles a mult/multu occupies the MD unit after issue (≥1)
- DIV_CYCLES, 32, cycles a div/divu occupies the MD unit after issue (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- RsD, RtD  in  5  source registers of the instruction in D
- RsE, RtE  in  5  source registers of the instruction in E
- WriteRegE, WriteRegM, WriteRegW  in  5  destination registers in E/M/W
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables in E/M/W
- MemtoRegE, MemtoRegM  in  1  load in E/M
- BranchD  in  1  branch in D, compared in D
- MdUseD  in  1  instruction in D is mult/div/mfhi/mflo/mthi/mtlo
- MdStartE  in  1  mult/div in E this cycle, one cycle per instruction
- MdIsDivE  in  1  qualifies MdStartE: 1 = div, 0 = mult
- StallF, StallD  out  1  hold the PC and the F/D register
- FlushE  out  1  clear the D/E register (insert bubble)
- ForwardAD, ForwardBD  out  1  D-stage compare operand from M result
- ForwardAE, ForwardBE  out  2  E-stage ALU operand select
- MdBusy  out  1  MD unit occupied
- MdDone  out  1  final MD cycle, HI/LO written at the end of this cycle
- MdErr  out  1  sticky: MdStartE seen while busy

## Operation
- Register $0 never matches in any comparison.
- Forwarding, ForwardAE (BE is identical with RtE):
  - 2'b10 if RegWriteM && WriteRegM==RsE.
  - Else 2'b01 if RegWriteW && WriteRegW==RsE.
  - Else 2'b00. M has priority over W.
- ForwardAD = RegWriteM && WriteRegM==RsD. ForwardBD is the same with RtD.
- lwstall = MemtoRegE && (WriteRegE==RsD || WriteRegE==RtD).
- branchstall = BranchD && ((RegWriteE && WriteRegE∈{RsD,RtD}) || (MemtoRegM && WriteRegM∈{RsD,RtD})).
- mdstall = MdUseD && (MdStartE || (state==BUSY && count!=0)).
- StallF = StallD = FlushE = lwstall | branchstall | mdstall.
- MD sequencer FSM has two states:
  - IDLE: on MdStartE, load count = (MdIsDivE ? DIV_CYCLES : MULT_CYCLES) − 1 and go to BUSY.
  - BUSY: if count==0, go to IDLE; else decrement count.
- MdBusy = (state==BUSY). MdDone = BUSY && count==0.
- MdStartE in BUSY: ignored (no reload, no state change) and MdErr sets. MdErr clears only on reset.
- MdStartE in the same cycle as MdDone: treated as BUSY, so it is ignored and sets MdErr. mdstall normally makes this impossible.

## Timing
- All stall, flush and forward outputs are combinational from the current inputs and the FSM state. No added latency.
- MdBusy, MdDone and MdErr are derived from registered state only.
- Reset (asynchronous assert, synchronous deassert at the clk edge):
  - state = IDLE, count = 0, MdErr = 0.
  - MdBusy = 0 and MdDone = 0.
  - With all inputs 0, every output is 0.
- MD issue at cycle t0 with latency N:
  - BUSY during t1..tN; MdDone in tN; IDLE at tN+1.
  - A HI/LO consumer in D at t0 stalls t0..tN−1, which is N cycles, and enters E at tN+1.
- Reset mid-BUSY aborts the sequence immediately. No MdDone pulse is produced.
- count is $clog2(max(MULT_CYCLES,DIV_CYCLES)) bits wide and never underflows.

## Structure
- Package hazard_pkg:
  - Forward select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - md_state_t enum {MD_IDLE, MD_BUSY}.
- Sub-module md_sequencer holds the FSM, count, MdBusy/MdDone/MdErr and a busy_pending output (BUSY && count!=0).
- hazard_unit is the top: combinational compare logic plus one md_sequencer instance.

## Test plan
- Load-use: MemtoRegE=1, WriteRegE=8, RsD=8 → StallF=StallD=FlushE=1 for exactly that cycle. Same stimulus with RsD=0, WriteRegE=0 → all 0.
- Forward priority: RegWriteM=RegWriteW=1, WriteRegM=WriteRegW=5, RsE=5 → ForwardAE=2'b10. Drop RegWriteM → 2'b01.
- Branch hazard: BranchD=1, RsD=3, RegWriteE=1, WriteRegE=3 → stall for 1 cycle. Next cycle: MemtoRegM=0, RegWriteM=1, WriteRegM=3 → no stall, ForwardAD=1.
- Multiply interlock (MULT_CYCLES=4): MdStartE at t0 with MdUseD=1 held → stall asserted t0..t3; MdDone at t4 only; MdBusy during t1..t4.
- Divide (DIV_CYCLES=32): MdBusy high for 32 cycles. A second MdStartE at cycle 10 → MdErr=1 and remains set, and MdDone still arrives on the original 32nd cycle.
- Reset: rst_n low at cycle 2 of a divide → MdBusy=0 asynchronously; no MdDone after release; MdUseD=1 no longer stalls.

Source files
------------

// File: rtl/hazard_pkg.sv
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types, forward-select encodings and compare helper
//                for the pipeline hazard controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // Register $0 is hard-wired, so a write to it is never a real producer.
    function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

endpackage

`default_nettype wire

// File: rtl/md_sequencer.sv
// ============================================================================
//  Module      : md_sequencer
//  Description : Busy sequencer for the multi-cycle multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_sequencer
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start,
    input  logic md_is_div,
    output logic md_busy,
    output logic md_done,
    output logic md_err,
    output logic busy_pending
);

    localparam int unsigned c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned c_cnt_w      = (c_max_cycles > 1) ? $clog2(c_max_cycles) : 1;
    localparam logic [c_cnt_w-1:0] c_mult_load = c_cnt_w'(MULT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_div_load  = c_cnt_w'(DIV_CYCLES - 1);

    md_state_t          r_state;
    md_state_t          w_state_nxt;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_count_nxt;
    logic               r_err;
    logic               w_err_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MD_IDLE;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // A start while busy (including the done cycle) is dropped and flagged.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_err_nxt   = r_err;
        case (r_state)
            MD_IDLE: begin
                if (md_start) begin
                    w_state_nxt = MD_BUSY;
                    w_count_nxt = md_is_div ? c_div_load : c_mult_load;
                end
            end
            MD_BUSY: begin
                if (md_start) begin
                    w_err_nxt = 1'b1;
                end
                if (r_count == '0) begin
                    w_state_nxt = MD_IDLE;
                end else begin
                    w_count_nxt = r_count - 1'b1;
                end
            end
            default: begin
                w_state_nxt = MD_IDLE;
            end
        endcase
    end

    always_comb begin
        md_busy      = (r_state == MD_BUSY);
        md_done      = (r_state == MD_BUSY) && (r_count == '0);
        busy_pending = (r_state == MD_BUSY) && (r_count != '0);
        md_err       = r_err;
    end

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
//  Module      : hazard_unit
//  Description : Stall, flush and forwarding control for the 5-stage core,
//                including the multiply/divide interlock.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       MemtoRegM,
    input  logic       BranchD,
    input  logic       MdUseD,
    input  logic       MdStartE,
    input  logic       MdIsDivE,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushE,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MdBusy,
    output logic       MdDone,
    output logic       MdErr
);

    logic w_lwstall;
    logic w_branchstall;
    logic w_mdstall;
    logic w_busy_pending;
    logic w_stall;

    md_sequencer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_sequencer (
        .clk          (clk),
        .rst_n        (rst_n),
        .md_start     (MdStartE),
        .md_is_div    (MdIsDivE),
        .md_busy      (MdBusy),
        .md_done      (MdDone),
        .md_err       (MdErr),
        .busy_pending (w_busy_pending)
    );

    always_comb begin
        ForwardAE = FWD_RF;
        if (RegWriteM && reg_hit(RsE, WriteRegM)) begin
            ForwardAE = FWD_MEM;
        end else if (RegWriteW && reg_hit(RsE, WriteRegW)) begin
            ForwardAE = FWD_WB;
        end

        ForwardBE = FWD_RF;
        if (RegWriteM && reg_hit(RtE, WriteRegM)) begin
            ForwardBE = FWD_MEM;
        end else if (RegWriteW && reg_hit(RtE, WriteRegW)) begin
            ForwardBE = FWD_WB;
        end
    end

    assign ForwardAD = RegWriteM && reg_hit(RsD, WriteRegM);
    assign ForwardBD = RegWriteM && reg_hit(RtD, WriteRegM);

    assign w_lwstall = MemtoRegE && (reg_hit(RsD, WriteRegE) || reg_hit(RtD, WriteRegE));

    // Branches compare in D, so an ALU result still in E or a load in M cannot be forwarded yet.
    assign w_branchstall = BranchD &&
        ((RegWriteE && (reg_hit(RsD, WriteRegE) || reg_hit(RtD, WriteRegE))) ||
         (MemtoRegM && (reg_hit(RsD, WriteRegM) || reg_hit(RtD, WriteRegM))));

    assign w_mdstall = MdUseD && (MdStartE || w_busy_pending);

    assign w_stall = w_lwstall | w_branchstall | w_mdstall;
    assign StallF  = w_stall;
    assign StallD  = w_stall;
    assign FlushE  = w_stall;

endmodule

`default_nettype wire
